// File: rtl/da_wave_play.sv
// rtl/da_wave_play.sv - FIFO-to-DAC sample playback paced by a phase accumulator
// Build option DA_UNDERRUN_HOLD_EN: keep the last played sample on the DAC after an underrun.
module da_wave_play #(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned PRIME_LVL = 16,
  parameter logic [7:0]  MIDSCALE  = 8'h80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [12:0] freq,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic [12:0] rd_data_count,
  output logic        fifo_rd_en,
  output logic [7:0]  da_data,
  output logic        da_clk,
  output logic        playing,
  output logic [15:0] underrun_cnt
);
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             rd_en_q, rd_en_d;
  logic             cap_q, cap_d;
  logic             und1_q, und1_d;
  logic             und2_q, und2_d;
  logic [7:0]       da_q, da_d;
  logic             da_clk_q, da_clk_d;
  logic             playing_q, playing_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [ACC_W:0]   sum;
  logic             go_idle;
  logic             tick;

  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(freq);
  assign go_idle = !enable || (freq == 13'd0);
  assign tick    = (state_q == PLAY) && sum[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rd_en_d = 1'b0;
    cap_d   = rd_en_q;
    und1_d  = 1'b0;
    und2_d  = und1_q;
    da_d    = da_q;
    cnt_d   = cnt_q;

    // Reads and underruns land on the DAC two clocks after their tick.
    if (cap_q) da_d = fifo_dout;
    if (und2_q) begin
`ifdef DA_UNDERRUN_HOLD_EN
      da_d = da_q;
`else
      da_d = MIDSCALE;
`endif
    end

    if (go_idle) begin
      state_d = IDLE;
      acc_d   = '0;
      cap_d   = 1'b0;
      und2_d  = 1'b0;
      da_d    = MIDSCALE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PRIME;
          da_d    = MIDSCALE;
        end
        PRIME: begin
          if ({19'd0, rd_data_count} >= PRIME_LVL) state_d = PLAY;
        end
        PLAY: begin
          acc_d = sum[ACC_W-1:0];
          if (tick) begin
            if (fifo_empty) begin
              und1_d  = 1'b1;
              state_d = PRIME;
              acc_d   = '0;
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end else begin
              rd_en_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    playing_d = (state_d == PLAY);
    da_clk_d  = (state_d == PLAY) && !acc_d[ACC_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      rd_en_q   <= 1'b0;
      cap_q     <= 1'b0;
      und1_q    <= 1'b0;
      und2_q    <= 1'b0;
      da_q      <= MIDSCALE;
      da_clk_q  <= 1'b0;
      playing_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rd_en_q   <= rd_en_d;
      cap_q     <= cap_d;
      und1_q    <= und1_d;
      und2_q    <= und2_d;
      da_q      <= da_d;
      da_clk_q  <= da_clk_d;
      playing_q <= playing_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fifo_rd_en   = rd_en_q;
  assign da_data      = da_q;
  assign da_clk       = da_clk_q;
  assign playing      = playing_q;
  assign underrun_cnt = cnt_q;
endmodule

// File: tb/tb_da_wave_play.sv
// tb/tb_da_wave_play.sv - bench for da_wave_play: event-queue model, vector table, directed corners
module tb_da_wave_play;
  localparam int         PRIME_S = 1;
  localparam int         PLAY_S  = 2;
  localparam int         IDLE_S  = 0;
  localparam logic [7:0] MID     = 8'h80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [12:0] freq = 13'd0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty = 1'b1;
  logic [12:0] rd_data_count = 13'd0;
  logic        fifo_rd_en;
  logic [7:0]  da_data;
  logic        da_clk;
  logic        playing;
  logic [15:0] underrun_cnt;

  always #5 clk = ~clk;

  da_wave_play #(.ACC_W(8), .PRIME_LVL(16), .MIDSCALE(8'h80)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq(freq),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .rd_data_count(rd_data_count),
    .fifo_rd_en(fifo_rd_en), .da_data(da_data), .da_clk(da_clk),
    .playing(playing), .underrun_cnt(underrun_cnt)
  );

  // Standard (non-FWFT) FIFO: data appears the clock after the read strobe.
  logic [7:0] mem[$];
  logic [7:0] last_pushed = 8'h00;
  logic       ovr = 1'b0;
  always @(posedge clk) if (fifo_rd_en && mem.size() > 0) fifo_dout <= mem.pop_front();

  typedef struct { int due; bit und; logic [7:0] w; } ev_t;
  ev_t  sched[$];
  int   m_state, m_acc, m_cnt, edge_n;
  logic [7:0] m_da;
  logic m_rd, m_dclk;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem.push_back(w);
    last_pushed = w;
  endtask

  task automatic top_up(input int n);
    while (mem.size() < n) push(8'($urandom));
  endtask

  task automatic model_reset();
    m_state = IDLE_S; m_acc = 0; m_cnt = 0; m_da = MID; m_rd = 0; m_dclk = 0;
    sched.delete();
  endtask

  // Predicts the outputs visible after the coming clock edge.
  task automatic model_edge();
    ev_t ev;
    int  s;
    edge_n++;
    m_rd = 1'b0;
    if (!enable || freq == 13'd0) begin
      m_state = IDLE_S; m_acc = 0; m_da = MID;
      sched.delete();
    end else begin
      while (sched.size() > 0 && sched[0].due <= edge_n) begin
        ev = sched.pop_front();
        if (!ev.und) m_da = ev.w;
        else begin
`ifndef DA_UNDERRUN_HOLD_EN
          m_da = MID;
`endif
        end
      end
      case (m_state)
        IDLE_S: begin m_state = PRIME_S; m_da = MID; end
        PRIME_S: if (int'(rd_data_count) >= 16) m_state = PLAY_S;
        default: begin
          s = m_acc + int'(freq);
          m_acc = s % 256;
          if (s >= 256) begin
            if (fifo_empty) begin
              if (m_cnt < 65535) m_cnt++;
              m_state = PRIME_S; m_acc = 0;
              sched.push_back('{due: edge_n + 2, und: 1'b1, w: 8'h00});
            end else begin
              m_rd = 1'b1;
              sched.push_back('{due: edge_n + 2, und: 1'b0, w: mem[0]});
            end
          end
        end
      endcase
    end
    m_dclk = (m_state == PLAY_S) && (m_acc < 128);
  endtask

  task automatic step();
    fifo_empty    = ovr ? 1'b1 : (mem.size() == 0);
    rd_data_count = ovr ? 13'd16 : 13'(mem.size());
    model_edge();
    @(posedge clk);
    #1;
    chk("rd_en", 32'(fifo_rd_en), 32'(m_rd));
    chk("da_data", 32'(da_data), 32'(m_da));
    chk("da_clk", 32'(da_clk), 32'(m_dclk));
    chk("playing", 32'(playing), 32'(m_state == PLAY_S));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_da_data", 32'(da_data), 32'h80);
    chk("rst_da_clk", 32'(da_clk), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic en; logic [12:0] fr; int fill; int cycles; logic exp_play; logic exp_rd; logic clr;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int   rd_steps[$];
    logic rd_seen;
    bit   found;
    int   prev, push_pct;

    vecs[0] = '{1'b0, 13'd64,  0,  3, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 13'd64,  15, 6, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 13'd64,  16, 1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 13'd64,  16, 6, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 13'd0,   16, 2, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 13'd127, 20, 12, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 13'd127, 0,  2, 1'b0, 1'b0, 1'b0};
    edge_n = 0;

    do_reset();

    // freq=64 on an 8-bit accumulator: tick every 4 clocks, sample on DAC 2 clocks later
    enable = 1'b1; freq = 13'd64;
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    for (int k = 1; k <= 18; k++) begin
      step();
      if (fifo_rd_en) rd_steps.push_back(k);
      if (k == 8)  chk("first_sample", 32'(da_data), 32'hA0);
      if (k == 12) chk("second_sample", 32'(da_data), 32'hA1);
    end
    chk("tick_count", 32'(rd_steps.size()), 32'd4);
    for (int i = 0; i < rd_steps.size() && i < 4; i++)
      chk("tick_step", 32'(rd_steps[i]), 32'(6 + 4 * i));

    foreach (vecs[v]) begin
      enable = vecs[v].en; freq = vecs[v].fr;
      top_up(vecs[v].fill);
      rd_seen = 1'b0;
      for (int k = 0; k < vecs[v].cycles; k++) begin
        step();
        rd_seen |= fifo_rd_en;
      end
      chk($sformatf("vec%0d_playing", v), 32'(playing), 32'(vecs[v].exp_play));
      chk($sformatf("vec%0d_rd_seen", v), 32'(rd_seen), 32'(vecs[v].exp_rd));
      if (vecs[v].clr) mem.delete();
    end

    // Drain the FIFO in PLAY until the first underrun
    enable = 1'b1; freq = 13'd127; top_up(16);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      prev = m_cnt;
      step();
      if (m_cnt != prev) begin found = 1; break; end
    end
    chk("underrun_seen", 32'(found), 32'd1);
    chk("underrun_cnt_one", 32'(underrun_cnt), 32'd1);
    chk("underrun_to_prime", 32'(playing), 32'd0);
    step(); step();
`ifdef DA_UNDERRUN_HOLD_EN
    chk("underrun_da", 32'(da_data), 32'(last_pushed));
`else
    chk("underrun_da", 32'(da_data), 32'h80);
`endif

    // Enable dropped on the very clock that would tick
    top_up(20); freq = 13'd64;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_state == PLAY_S && m_acc + int'(freq) >= 256) begin found = 1; break; end
      step();
    end
    chk("tick_found", 32'(found), 32'd1);
    enable = 1'b0;
    step();
    chk("drop_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("drop_da", 32'(da_data), 32'h80);
    chk("drop_playing", 32'(playing), 32'd0);

    // Reset in the middle of playback
    enable = 1'b1; top_up(20);
    for (int k = 0; k < 10; k++) step();
    chk("pre_reset_playing", 32'(playing), 32'd1);
    do_reset();

    push_pct = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) push_pct = $urandom_range(20, 90);
      if (k % 25 == 0) freq = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 127));
      enable = ($urandom_range(0, 59) != 0);
      if (mem.size() < 40 && $urandom_range(0, 99) < push_pct) push(8'($urandom));
      step();
    end

    // Saturation: preload the counter near the top, then underrun repeatedly
    enable = 1'b0; freq = 13'd127; ovr = 1'b1;
    step();
    m_cnt = 65532;
    force dut.cnt_q = 16'hFFFC;
    step(); step();
    release dut.cnt_q;
    enable = 1'b1;
    for (int k = 0; k < 40; k++) step();
    chk("cnt_saturated", 32'(underrun_cnt), 32'hFFFF);
    ovr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
